// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared op/state encodings and default latency for the multiply controller
package mul_pkg;

  localparam logic [1:0] MUL_OP_W  = 2'b00;
  localparam logic [1:0] MUL_OP_H  = 2'b01;
  localparam logic [1:0] MUL_OP_HU = 2'b10;

  localparam int MUL_LAT_DEFAULT = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/Mul_33.sv
// rtl/Mul_33.sv - combinational 33x33 signed multiplier, timed as a multicycle path by its controller
module Mul_33 (
  input  logic [32:0] a,
  input  logic [32:0] b,
  output logic [65:0] prod
);

  logic signed [65:0] w_a;
  logic signed [65:0] w_b;

  assign w_a  = {{33{a[32]}}, a};
  assign w_b  = {{33{b[32]}}, b};
  assign prod = w_a * w_b;

endmodule

// File: rtl/mul_ctrl.sv
// rtl/mul_ctrl.sv - MUL.W/MULH.W/MULH.WU sequencer around Mul_33
// Optional zero-operand shortcut is built when MUL_ZERO_BYPASS_EN is defined.
module mul_ctrl
  import mul_pkg::*;
#(
  parameter int LAT   = MUL_LAT_DEFAULT,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_res,
  output logic        busy
);

  mul_state_t       r_state;
  mul_state_t       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [32:0]      r_a;
  logic [32:0]      r_b;
  logic [1:0]       r_op;
  logic [31:0]      r_res;
  logic [65:0]      w_prod;
  logic [31:0]      w_sel;
  logic             w_accept;
  logic             w_capture;
  logic             w_zero;
  logic             w_ext1;
  logic             w_ext2;
  logic             w_unused;

  // Only MULH.WU zero-extends; the low word does not depend on the extension.
  assign w_ext1 = (op == MUL_OP_HU) ? 1'b0 : src1[31];
  assign w_ext2 = (op == MUL_OP_HU) ? 1'b0 : src2[31];

`ifdef MUL_ZERO_BYPASS_EN
  assign w_zero = (src1 == 32'd0) || (src2 == 32'd0);
`else
  assign w_zero = 1'b0;
`endif

  Mul_33 u_mul (
    .a    (r_a),
    .b    (r_b),
    .prod (w_prod)
  );

  assign w_sel    = ((r_op == MUL_OP_H) || (r_op == MUL_OP_HU)) ? w_prod[63:32] : w_prod[31:0];
  assign w_unused = ^w_prod[65:64];
  assign out_res  = r_res;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = !rst;
        w_accept = in_valid && !rst && !flush;
        if (w_accept) w_next = w_zero ? S_DONE : S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (r_cnt == '0) begin
          w_capture = 1'b1;
          w_next    = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Flush wins over accept, capture and completion; out_res keeps its stale value.
    if (flush) begin
      w_next    = S_IDLE;
      w_capture = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_op  <= MUL_OP_W;
      r_res <= '0;
    end else begin
      if (w_accept) begin
        r_a   <= {w_ext1, src1};
        r_b   <= {w_ext2, src2};
        r_op  <= op;
        r_cnt <= CNT_W'(LAT - 1);
        if (w_zero) r_res <= '0;
      end else if ((r_state == S_CALC) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_capture) r_res <= w_sel;
    end
  end

endmodule
